// File: rtl/ika_clkgen_pkg.sv
// ika_clkgen_pkg: sequencer states, hold-counter width and divider helpers for ika_clkgen
package ika_clkgen_pkg;
  typedef enum logic [1:0] {ASSERT, COUNT, ALIGN, RUN} seq_t;
  localparam int IC_CNT_W = 16;
  function automatic int unsigned clamp_den(input int unsigned den);
    return den == 0 ? 1 : den;
  endfunction
endpackage

// File: rtl/ika_clkgen_nco.sv
// ika_clkgen_nco: fractional phase-accumulator divider producing the phiM clock enable
// Build option IKA_CLKGEN_RUNTIME_DIV_EN adds run-time numerator/denominator inputs.
module ika_clkgen_nco
  import ika_clkgen_pkg::*;
#(
  parameter int ACC_W   = 8,
  parameter int DIV_NUM = 1,
  parameter int DIV_DEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             active,
`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
  input  logic [ACC_W-1:0] div_num,
  input  logic [ACC_W-1:0] div_den,
`endif
  output logic             fire,
  output logic             pcen_n
);
  logic [ACC_W-1:0] acc, acc_nx, num, den;
  logic [ACC_W:0]   sum, den_eff;
  logic             clamp;
`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
  logic [ACC_W-1:0] num_q, den_q;
  logic [ACC_W:0]   den_new;
  // shadows only move on an enable edge so a period is never cut short
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      num_q <= ACC_W'(DIV_NUM);
      den_q <= ACC_W'(DIV_DEN);
    end else if (!active || fire) begin
      num_q <= div_num;
      den_q <= div_den;
    end
  assign num     = num_q;
  assign den     = den_q;
  assign den_new = (ACC_W+1)'(clamp_den(32'(div_den)));
`else
  assign num = ACC_W'(DIV_NUM);
  assign den = ACC_W'(DIV_DEN);
`endif
  always_comb begin
    den_eff = (ACC_W+1)'(clamp_den(32'(den)));
    sum     = {1'b0, acc} + {1'b0, num};
    clamp   = {1'b0, num} >= den_eff;
    fire    = active && (clamp || sum >= den_eff);
    acc_nx  = clamp ? '0 : sum >= den_eff ? ACC_W'(sum - den_eff) : ACC_W'(sum);
`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
    if (fire && {1'b0, acc_nx} >= den_new) acc_nx = '0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc    <= '0;
      pcen_n <= 1'b1;
    end else if (active) begin
      acc    <= acc_nx;
      pcen_n <= ~fire;
    end
endmodule

// File: rtl/ika_clkgen.sv
// ika_clkgen: phiM/phi1 clock-enable generator and stretched phi1-aligned chip initial-clear
// Build option IKA_CLKGEN_RUNTIME_DIV_EN adds i_DIV_NUM/i_DIV_DEN run-time divider ports.
module ika_clkgen
  import ika_clkgen_pkg::*;
#(
  parameter int ACC_W   = 8,
  parameter int DIV_NUM = 1,
  parameter int DIV_DEN = 4,
  parameter int IC_HOLD = 64
) (
  input  logic             i_EMUCLK,
  input  logic             i_IC_n,
`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
  input  logic [ACC_W-1:0] i_DIV_NUM,
  input  logic [ACC_W-1:0] i_DIV_DEN,
`endif
  output logic             o_phiM_PCEN_n,
  output logic             o_phi1,
  output logic             o_phi1_PCEN_n,
  output logic             o_phi1_NCEN_n,
  output logic             o_IC_n
);
  logic [1:0]          sync;
  logic                active, fire;
  seq_t                state, state_nx;
  logic [IC_CNT_W-1:0] cnt, cnt_nx;
  always_ff @(posedge i_EMUCLK or negedge i_IC_n)
    if (!i_IC_n) sync <= '0;
    else sync <= {sync[0], 1'b1};
  assign active = sync[1];
  ika_clkgen_nco #(.ACC_W(ACC_W), .DIV_NUM(DIV_NUM), .DIV_DEN(DIV_DEN)) u_nco (
    .clk    (i_EMUCLK),
    .rst_n  (i_IC_n),
    .active (active),
`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
    .div_num(i_DIV_NUM),
    .div_den(i_DIV_DEN),
`endif
    .fire   (fire),
    .pcen_n (o_phiM_PCEN_n)
  );
  // phi1 and its enables are registered on the same edge as the phiM enable
  always_ff @(posedge i_EMUCLK or negedge i_IC_n)
    if (!i_IC_n) begin
      o_phi1        <= 1'b0;
      o_phi1_PCEN_n <= 1'b1;
      o_phi1_NCEN_n <= 1'b1;
    end else begin
      o_phi1        <= o_phi1 ^ fire;
      o_phi1_PCEN_n <= ~(fire & ~o_phi1);
      o_phi1_NCEN_n <= ~(fire & o_phi1);
    end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ASSERT: state_nx = active ? COUNT : ASSERT;
      COUNT: if (!o_phiM_PCEN_n) begin
        cnt_nx   = cnt + IC_CNT_W'(1);
        state_nx = cnt_nx == IC_CNT_W'(IC_HOLD) ? ALIGN : COUNT;
      end
      ALIGN: state_nx = !o_phi1_PCEN_n ? RUN : ALIGN;
      default: state_nx = RUN;
    endcase
  end
  always_ff @(posedge i_EMUCLK or negedge i_IC_n)
    if (!i_IC_n) begin
      state  <= ASSERT;
      cnt    <= '0;
      o_IC_n <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      o_IC_n <= state_nx == RUN;
    end
endmodule

// File: tb/tb_ika_clkgen.sv
// tb_ika_clkgen: directed checks of ika_clkgen divider ratios, phi1 enables and IC sequencing
module tb_ika_clkgen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] div_num = 8'd1, div_den = 8'd4;
  logic [5:0] pm, p1, pc, nc, ic;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;

  ika_clkgen #(.ACC_W(8), .DIV_NUM(1), .DIV_DEN(4), .IC_HOLD(64)) u0 (
    .i_EMUCLK(clk), .i_IC_n(rst_n),
`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
    .i_DIV_NUM(div_num), .i_DIV_DEN(div_den),
`endif
    .o_phiM_PCEN_n(pm[0]), .o_phi1(p1[0]), .o_phi1_PCEN_n(pc[0]), .o_phi1_NCEN_n(nc[0]), .o_IC_n(ic[0]));
  ika_clkgen #(.ACC_W(8), .DIV_NUM(3), .DIV_DEN(8), .IC_HOLD(64)) u1 (
    .i_EMUCLK(clk), .i_IC_n(rst_n),
`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
    .i_DIV_NUM(8'd3), .i_DIV_DEN(8'd8),
`endif
    .o_phiM_PCEN_n(pm[1]), .o_phi1(p1[1]), .o_phi1_PCEN_n(pc[1]), .o_phi1_NCEN_n(nc[1]), .o_IC_n(ic[1]));
  ika_clkgen #(.ACC_W(8), .DIV_NUM(1), .DIV_DEN(2), .IC_HOLD(5)) u2 (
    .i_EMUCLK(clk), .i_IC_n(rst_n),
`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
    .i_DIV_NUM(8'd1), .i_DIV_DEN(8'd2),
`endif
    .o_phiM_PCEN_n(pm[2]), .o_phi1(p1[2]), .o_phi1_PCEN_n(pc[2]), .o_phi1_NCEN_n(nc[2]), .o_IC_n(ic[2]));
  ika_clkgen #(.ACC_W(8), .DIV_NUM(0), .DIV_DEN(4), .IC_HOLD(5)) u3 (
    .i_EMUCLK(clk), .i_IC_n(rst_n),
`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
    .i_DIV_NUM(8'd0), .i_DIV_DEN(8'd4),
`endif
    .o_phiM_PCEN_n(pm[3]), .o_phi1(p1[3]), .o_phi1_PCEN_n(pc[3]), .o_phi1_NCEN_n(nc[3]), .o_IC_n(ic[3]));
  ika_clkgen #(.ACC_W(8), .DIV_NUM(9), .DIV_DEN(4), .IC_HOLD(5)) u4 (
    .i_EMUCLK(clk), .i_IC_n(rst_n),
`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
    .i_DIV_NUM(8'd9), .i_DIV_DEN(8'd4),
`endif
    .o_phiM_PCEN_n(pm[4]), .o_phi1(p1[4]), .o_phi1_PCEN_n(pc[4]), .o_phi1_NCEN_n(nc[4]), .o_IC_n(ic[4]));
  ika_clkgen #(.ACC_W(8), .DIV_NUM(1), .DIV_DEN(0), .IC_HOLD(5)) u5 (
    .i_EMUCLK(clk), .i_IC_n(rst_n),
`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
    .i_DIV_NUM(8'd1), .i_DIV_DEN(8'd0),
`endif
    .o_phiM_PCEN_n(pm[5]), .o_phi1(p1[5]), .o_phi1_PCEN_n(pc[5]), .o_phi1_NCEN_n(nc[5]), .o_IC_n(ic[5]));

  task automatic hold_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #11;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({pm[i], p1[i], pc[i], nc[i], ic[i]} !== 5'b10110)
        $display("FAIL reset u%0d got %b want 10110", i, {pm[i], p1[i], pc[i], nc[i], ic[i]});
      else passes++;
    end
  endtask

  task automatic test_integer();
    int k, p;
    logic [3:0] exp;
    logic e;
    hold_reset(2);
    for (int n = 1; n <= 270; n++) begin
      step();
      k = n - 2;
      p = k >= 1 ? k / 4 : 0;
      exp[3] = !(k >= 1 && k % 4 == 0);
      exp[2] = p % 2 == 1;
      exp[1] = !(!exp[3] && p % 2 == 1);
      exp[0] = !(!exp[3] && p % 2 == 0);
      checks++;
      if ({pm[0], p1[0], pc[0], nc[0]} !== exp)
        $display("FAIL integer k=%0d got %b want %b", k, {pm[0], p1[0], pc[0], nc[0]}, exp);
      else passes++;
      e = k >= 261;
      checks++;
      if (ic[0] !== e) $display("FAIL integer_ic k=%0d got %b want %b", k, ic[0], e);
      else passes++;
    end
  endtask

  task automatic test_fractional();
    int k, pulses;
    logic e;
    pulses = 0;
    hold_reset(2);
    for (int n = 1; n <= 802; n++) begin
      step();
      k = n - 2;
      e = !(k >= 1 && (3 * k) / 8 != (3 * (k - 1)) / 8);
      checks++;
      if (pm[1] !== e) $display("FAIL fractional k=%0d got %b want %b", k, pm[1], e);
      else passes++;
      if (k >= 1 && k <= 800 && pm[1] === 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 300) $display("FAIL fractional_count got %0d want 300", pulses);
    else passes++;
  endtask

  task automatic check_hold_seq(input string tag);
    int k;
    logic [1:0] exp;
    for (int n = 1; n <= 40; n++) begin
      step();
      k = n - 2;
      exp = {!(k >= 2 && k % 2 == 0), k >= 15};
      checks++;
      if ({pm[2], ic[2]} !== exp) $display("FAIL %s k=%0d got %b want %b", tag, k, {pm[2], ic[2]}, exp);
      else passes++;
    end
  endtask

  task automatic test_hold();
    hold_reset(2);
    check_hold_seq("hold");
  endtask

  task automatic test_boundaries();
    int k;
    logic [1:0] e5;
    logic e4;
    hold_reset(2);
    for (int n = 1; n <= 1002; n++) begin
      step();
      k = n - 2;
      checks++;
      if ({pm[3], ic[3]} !== 2'b10) $display("FAIL num_zero k=%0d got %b want 10", k, {pm[3], ic[3]});
      else passes++;
      e4 = !(k >= 1);
      checks++;
      if (pm[4] !== e4) $display("FAIL num_ge_den k=%0d got %b want %b", k, pm[4], e4);
      else passes++;
      e5 = {!(k >= 1), k >= 1 && k % 2 == 1};
      checks++;
      if ({pm[5], p1[5]} !== e5) $display("FAIL den_zero k=%0d got %b want %b", k, {pm[5], p1[5]}, e5);
      else passes++;
    end
  endtask

  task automatic test_mid_reset();
    checks++;
    if ({ic[2], pm[4]} !== 2'b10) $display("FAIL mid_pre got %b want 10", {ic[2], pm[4]});
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({pm[i], p1[i], pc[i], nc[i], ic[i]} !== 5'b10110)
        $display("FAIL mid_async u%0d got %b want 10110", i, {pm[i], p1[i], pc[i], nc[i], ic[i]});
      else passes++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_hold_seq("mid_rerun");
  endtask

`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
  task automatic test_runtime();
    int k;
    logic e;
    div_num = 8'd1;
    div_den = 8'd4;
    hold_reset(2);
    for (int n = 1; n <= 22; n++) begin
      step();
      k = n - 2;
      e = !(k == 4 || (k >= 8 && k % 2 == 0));
      checks++;
      if (pm[0] !== e) $display("FAIL runtime k=%0d got %b want %b", k, pm[0], e);
      else passes++;
      if (k == 5) begin
        div_num = 8'd1;
        div_den = 8'd2;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_integer();
    test_fractional();
    test_hold();
    test_boundaries();
    test_mid_reset();
`ifdef IKA_CLKGEN_RUNTIME_DIV_EN
    test_runtime();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/ika_clkgen.md
Name: ika_clkgen

Overview:
- Parametrised master-clock-enable and chip-reset sequencer for the IKA sound-chip cores.
- Replaces the fixed divide-by-4 phiM enable with a fractional phase-accumulator divider.
- Derives the phi1 level and phi1 rising/falling clock enables from the phiM enables.
- Produces a stretched, phi1-aligned chip initial-clear for the IKA2151 core and its siblings.

Parameters:
- ACC_W, 8: accumulator width in bits; DIV_NUM and DIV_DEN must both fit in ACC_W bits.
- DIV_NUM, 1: accumulator increment per i_EMUCLK cycle.
- DIV_DEN, 4: accumulator modulus. phiM rate = EMUCLK × NUM/DEN.
- IC_HOLD, 64: minimum number of phiM enables that o_IC_n is held low after reset release; legal range 1..65535.

Ports:
- i_EMUCLK  in  1  system clock; the only clock.
- i_IC_n  in  1  reset, asynchronous, active-low.
- o_phiM_PCEN_n  out  1  phiM clock enable, active-low, 1 EMUCLK wide.
- o_phi1  out  1  phi1 level.
- o_phi1_PCEN_n  out  1  low on the phiM enable where phi1 rises.
- o_phi1_NCEN_n  out  1  low on the phiM enable where phi1 falls.
- o_IC_n  out  1  synchronous chip initial-clear to the cores, active-low.

Behaviour:
- Reset: one clock domain; reset is asynchronous, active-low. While i_IC_n is low, all state clears immediately:
  - accumulator = 0, hold counter = 0;
  - o_phiM_PCEN_n = 1, o_phi1 = 0, o_phi1_PCEN_n = 1, o_phi1_NCEN_n = 1, o_IC_n = 0.
- Release synchroniser: de-assertion passes through a 2-flop synchroniser. Logic is active from the 3rd i_EMUCLK rising edge after i_IC_n rises.
- Divider, evaluated each active cycle:
  - sum = acc + DIV_NUM, computed in ACC_W+1 bits.
  - If sum ≥ DIV_DEN: acc <= sum − DIV_DEN and o_phiM_PCEN_n <= 0 (registered). Otherwise acc <= sum and o_phiM_PCEN_n <= 1.
  - Latency: the output is low in the cycle immediately after the evaluating edge.
- Divider boundaries:
  - DIV_NUM = 0: no enables ever; all phi outputs hold their values.
  - DIV_NUM ≥ DIV_DEN: the enable is low every active cycle (clamped; acc stays 0).
  - DIV_DEN = 0: treated as 1.
- phi1 generation, on each phiM enable cycle:
  - o_phi1 toggles.
  - o_phi1_PCEN_n is low in the same cycle if the toggle is 0→1; o_phi1_NCEN_n is low if the toggle is 1→0.
  - Both phi1 enables are coincident with o_phiM_PCEN_n and are never low together.
- Reset sequencer, states: ASSERT → COUNT → ALIGN → RUN.
  - ASSERT: entered on reset. Moves to COUNT on the first active cycle.
  - COUNT: the 16-bit hold counter increments on each phiM enable. When it reaches IC_HOLD, moves to ALIGN.
  - ALIGN: on the next cycle where o_phi1_PCEN_n is low, o_IC_n <= 1 (registered, one cycle later) and the state moves to RUN.
  - RUN: o_IC_n stays 1 until reset.
  - Reset asserted in any state forces ASSERT asynchronously and o_IC_n = 0.
- Reset mid-operation: the accumulator phase is lost; after release the divider restarts from acc = 0 and phi1 restarts from 0.

Optional Feature:
- Macro: IKA_CLKGEN_RUNTIME_DIV_EN.
- Defined:
  - Adds ports i_DIV_NUM [ACC_W-1:0] and i_DIV_DEN [ACC_W-1:0].
  - Both are sampled into shadow registers only on cycles where o_phiM_PCEN_n is being driven low, and at reset release. This avoids mid-period glitches.
  - The shadow registers reset to the DIV_NUM and DIV_DEN parameter values.
  - If the loaded acc ≥ the new denominator, acc is cleared to 0.
- Undefined: the ports are absent and the divider uses the parameters as constants.

Decomposition:
- Package ika_clkgen_pkg contains:
  - the sequencer state enum (ASSERT, COUNT, ALIGN, RUN);
  - the hold-counter width constant IC_CNT_W = 16;
  - a function clamp_den() that maps 0 to 1.
- One sub-module, ika_clkgen_nco: the accumulator and phiM enable, instantiated once.
- phi1 generation and the reset sequencer stay in the top module.

Test Plan:
- Integer ratio: NUM=1, DEN=4, release reset.
  - o_phiM_PCEN_n is low on active cycle 4, then every 4th cycle.
  - o_phi1 toggles on each pulse; the first pulse is a phi1 PCEN.
- Fractional ratio: NUM=3, DEN=8.
  - Enable intervals repeat 3,3,2 EMUCLK (pulses on active cycles 3, 6, 8, 11, 14, 16).
  - Over 800 cycles there are exactly 300 pulses.
- Hold and alignment: IC_HOLD=5, NUM=1, DEN=2.
  - o_IC_n rises one cycle after the first phi1 PCEN following the 5th phiM enable.
  - The check confirms o_IC_n is never high earlier.
- Boundaries:
  - NUM=0: no pulses in 1000 cycles and o_IC_n stays 0.
  - NUM=9, DEN=4: the enable is low every active cycle.
  - DEN=0: behaves as DEN=1.
- Mid-run reset: pulse i_IC_n low for 3 cycles while in RUN.
  - All outputs return to reset values within the same cycle, asynchronously.
  - The full ASSERT→RUN sequence repeats.
- Runtime divider (macro defined): change i_DIV_NUM/i_DIV_DEN from 1/4 to 1/2 mid-period.
  - The old period completes, then the interval is 2 cycles.
  - No pulse is shorter than 1 cycle and no interval is shorter than 2.
